// File: rtl/apb4_master_arb_if.sv
// Bundle of the APB4 bus plus the per-channel request/response lanes seen by apb4_master_arb.
// master = the arbiter side; slave = the fabric/initiator side that drives requests and PREADY.
interface apb4_master_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NCH    = 2
);
  localparam int STRB_W = DATA_W / 8;

  logic                     PSEL;
  logic                     PENABLE;
  logic [ADDR_W-1:0]        PADDR;
  logic [2:0]               PPROT;
  logic                     PWRITE;
  logic [DATA_W-1:0]        PWDATA;
  logic [STRB_W-1:0]        PSTRB;
  logic                     PREADY;
  logic [DATA_W-1:0]        PRDATA;
  logic                     PSLVERR;

  logic [NCH-1:0]           req_valid;
  logic [NCH-1:0]           req_ready;
  logic [NCH-1:0]           req_write;
  logic [NCH*ADDR_W-1:0]    req_addr;
  logic [NCH*DATA_W-1:0]    req_wdata;
  logic [NCH*STRB_W-1:0]    req_strb;
  logic [NCH*3-1:0]         req_prot;

  logic [NCH-1:0]           rsp_valid;
  logic [DATA_W-1:0]        rsp_rdata;
  logic                     rsp_err;
  logic                     rsp_tout;

  modport master (
    output PSEL, PENABLE, PADDR, PPROT, PWRITE, PWDATA, PSTRB,
    input  PREADY, PRDATA, PSLVERR,
    input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_tout
  );

  modport slave (
    input  PSEL, PENABLE, PADDR, PPROT, PWRITE, PWDATA, PSTRB,
    output PREADY, PRDATA, PSLVERR,
    output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_tout
  );
endinterface

// File: rtl/apb4_master_arb.sv
// Multi-channel APB4 master: round-robin arbitration of NCH request lanes onto one APB4 bus,
// with back-to-back SETUP after a completing ACCESS and an optional PREADY timeout abort.
module apb4_master_arb #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NCH     = 2,
  parameter int TIMEOUT = 16
) (
  input  logic               PCLK,
  input  logic               PRESET,
  apb4_master_arb_if.master  bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic [NCH-1:0]   CH_ONE  = NCH'(1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     rr_q, rr_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [2:0]          pprot_q, pprot_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]   pstrb_q, pstrb_d;
  logic [NCH-1:0]      rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_tout_q, rsp_tout_d;

  logic                any_valid;
  logic [CH_W-1:0]     win;
  logic [CH_W-1:0]     cand;
  logic                grant_win;
  logic                accept;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;
  logic [STRB_W-1:0]   win_strb;
  logic [2:0]          win_prot;
  logic                win_write;

  // Scan from the farthest offset down so the channel nearest the pointer is written last and wins.
  always_comb begin
    any_valid = 1'b0;
    win       = '0;
    cand      = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      cand = CH_W'((int'(rr_q) + k) % NCH);
      if (bus.req_valid[cand]) begin
        any_valid = 1'b1;
        win       = cand;
      end
    end
  end

  always_comb begin
    win_addr  = '0;
    win_wdata = '0;
    win_strb  = '0;
    win_prot  = '0;
    win_write = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (win == CH_W'(i)) begin
        win_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        win_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
        win_strb  = bus.req_strb[i*STRB_W +: STRB_W];
        win_prot  = bus.req_prot[i*3 +: 3];
        win_write = bus.req_write[i];
      end
    end
  end

  // A timeout abort has PREADY low, so it never opens a grant window.
  assign grant_win     = (state_q == IDLE) || ((state_q == ACCESS) && bus.PREADY);
  assign accept        = grant_win && any_valid;
  assign bus.req_ready = accept ? (CH_ONE << win) : '0;

  always_comb begin
    // NOTE: every _d gets its hold/idle value first, so no path through this block infers a latch.
    state_d     = state_q;
    rr_d        = rr_q;
    ch_d        = ch_q;
    cnt_d       = cnt_q;
    paddr_d     = paddr_q;
    pprot_d     = pprot_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    rsp_tout_d  = 1'b0;

    if (accept) begin
      rr_d     = (int'(win) == NCH - 1) ? '0 : win + 1'b1;
      ch_d     = win;
      paddr_d  = win_addr;
      pprot_d  = win_prot;
      pwrite_d = win_write;
      pwdata_d = win_write ? win_wdata : '0;
      pstrb_d  = win_write ? win_strb  : '0;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) state_d = SETUP;
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = CNT_W'(1);
      end
      ACCESS: begin
        if (bus.PREADY) begin
          state_d     = accept ? SETUP : IDLE;
          rsp_valid_d = CH_ONE << ch_q;
          rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
          rsp_err_d   = bus.PSLVERR;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_MAX)) begin
          state_d     = IDLE;
          rsp_valid_d = CH_ONE << ch_q;
          rsp_err_d   = 1'b1;
          rsp_tout_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    psel_d    = (state_d != IDLE);
    penable_d = (state_d == ACCESS);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      ch_q        <= '0;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pprot_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tout_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      ch_q        <= ch_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pprot_q     <= pprot_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tout_q  <= rsp_tout_d;
    end
  end

  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PPROT     = pprot_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PSTRB     = pstrb_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_tout  = rsp_tout_q;

endmodule
